// File: rtl/function_table_interp_if.sv
// Streaming handshake bundle for the table-based function evaluator.
// The master drives samples in and accepts results; the slave is the evaluator.
interface function_table_interp_if #(
  parameter int WIDTH_X   = 8,
  parameter int WIDTH_Y   = 8,
  parameter int WIDTH_TAG = 2
);
  logic                 iValid;
  logic                 oReady;
  logic [WIDTH_X-1:0]   iData;
  logic [WIDTH_TAG-1:0] iTag;
  logic                 oValid;
  logic                 iReady;
  logic [WIDTH_Y-1:0]   oData;
  logic [WIDTH_TAG-1:0] oTag;

  modport master (
    output iValid, iData, iTag, iReady,
    input  oReady, oValid, oData, oTag
  );

  modport slave (
    input  iValid, iData, iTag, iReady,
    output oReady, oValid, oData, oTag
  );
endinterface

// File: rtl/function_table_interp.sv
// Pipelined function evaluator: coarse constant table of 2^ADDR_BITS+1 samples
// with linear interpolation on the low F = WIDTH_X-ADDR_BITS input bits.
// Three stages (index split, table fetch, multiply-add), a single global
// enable driven by output back-pressure, and a tag carried with each sample.
module function_table_interp #(
  parameter int    WIDTH_X   = 8,
  parameter int    WIDTH_Y   = 8,
  parameter int    ADDR_BITS = 4,
  parameter int    WIDTH_TAG = 2,
  parameter real   SCALE_X   = 1.0,
  parameter real   SCALE_Y   = 1.0,
  parameter string TARGET    = "id"
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  function_table_interp_if.slave bus
);

  localparam int F  = WIDTH_X - ADDR_BITS;
  localparam int RW = (F > 0) ? F : 1;
  localparam int N  = 2 ** ADDR_BITS;
  localparam int PW = WIDTH_Y + F + 2;

  // One table entry: scaled target function, rounded half away from zero,
  // saturated to the signed output range. Unknown targets give all-X.
  function automatic logic signed [WIDTH_Y-1:0] tbl_entry(input int k);
    real x, f, v, rv, lim_hi, lim_lo;
    logic signed [WIDTH_Y-1:0] res;
    x      = SCALE_X * (real'(k) / real'(N) - 0.5);
    lim_hi = real'(2 ** (WIDTH_Y - 1) - 1);
    lim_lo = -lim_hi - 1.0;
    f      = 0.0;
    res    = '0;
    if (TARGET == "id")           f = x;
    else if (TARGET == "sin")     f = $sin(x);
    else if (TARGET == "cos")     f = $cos(x);
    else if (TARGET == "tanh")    f = $tanh(x);
    else if (TARGET == "sigmoid") f = 1.0 / (1.0 + $exp(-x));
    else                          res = 'x;
    if (TARGET == "id" || TARGET == "sin" || TARGET == "cos" ||
        TARGET == "tanh" || TARGET == "sigmoid") begin
      v  = SCALE_Y * lim_hi * f;
      rv = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
      if (rv > lim_hi)      res = WIDTH_Y'(2 ** (WIDTH_Y - 1) - 1);
      else if (rv < lim_lo) res = WIDTH_Y'(-(2 ** (WIDTH_Y - 1)));
      else                  res = WIDTH_Y'($rtoi(rv));
    end
    return res;
  endfunction

  // Constant lookup table, fully resolved at elaboration.
  logic signed [WIDTH_Y-1:0] tbl [0:N];
  for (genvar gi = 0; gi <= N; gi++) begin : g_tbl
    assign tbl[gi] = tbl_entry(gi);
  end

  // Offset-binary view of the argument: upper bits index, lower bits fraction.
  logic [WIDTH_X-1:0]   u_w;
  logic [ADDR_BITS-1:0] k_in;
  logic [RW-1:0]        r_in;
  assign u_w  = {~bus.iData[WIDTH_X-1], bus.iData[WIDTH_X-2:0]};
  assign k_in = u_w[WIDTH_X-1 -: ADDR_BITS];
  if (F > 0) begin : g_r_split
    assign r_in = u_w[RW-1:0];
  end else begin : g_r_none
    assign r_in = '0;
  end

  // Pipeline state.
  logic                        v1_q, v1_d;
  logic [ADDR_BITS-1:0]        k1_q, k1_d;
  logic [RW-1:0]               r1_q, r1_d;
  logic [WIDTH_TAG-1:0]        tag1_q, tag1_d;
  logic                        v2_q, v2_d;
  logic signed [WIDTH_Y-1:0]   t2_q, t2_d;
  logic signed [WIDTH_Y:0]     d2_q, d2_d;
  logic [RW-1:0]               r2_q, r2_d;
  logic [WIDTH_TAG-1:0]        tag2_q, tag2_d;
  logic                        ov_q, ov_d;
  logic [WIDTH_Y-1:0]          od_q, od_d;
  logic [WIDTH_TAG-1:0]        ot_q, ot_d;

  logic                        en;
  logic signed [WIDTH_Y-1:0]   y_w;

  assign en         = ~ov_q | bus.iReady;
  assign bus.oReady = en;
  assign bus.oValid = ov_q;
  assign bus.oData  = od_q;
  assign bus.oTag   = ot_q;

  if (F > 0) begin : g_interp
    logic signed [PW-1:0] d_ext, r_ext, prod, acc;
    // Interpolate: base sample plus rounded slope times fraction.
    always_comb begin
      d_ext = PW'(d2_q);
      r_ext = PW'({1'b0, r2_q});
      prod  = d_ext * r_ext;
      acc   = (prod + PW'(2 ** (F - 1))) >>> F;
      y_w   = WIDTH_Y'(PW'(t2_q) + acc);
    end
  end else begin : g_lookup
    // No fraction bits: the table sample is the result.
    always_comb begin
      y_w = t2_q;
    end
  end

  // Next-state for all stages; everything holds when the output is stalled.
  always_comb begin
    v1_d   = v1_q;
    k1_d   = k1_q;
    r1_d   = r1_q;
    tag1_d = tag1_q;
    v2_d   = v2_q;
    t2_d   = t2_q;
    d2_d   = d2_q;
    r2_d   = r2_q;
    tag2_d = tag2_q;
    ov_d   = ov_q;
    od_d   = od_q;
    ot_d   = ot_q;
    if (en) begin
      v1_d   = bus.iValid;
      k1_d   = k_in;
      r1_d   = r_in;
      tag1_d = bus.iTag;
      v2_d   = v1_q;
      t2_d   = tbl[{1'b0, k1_q}];
      d2_d   = (WIDTH_Y + 1)'(tbl[{1'b0, k1_q} + 1'b1]) - (WIDTH_Y + 1)'(tbl[{1'b0, k1_q}]);
      r2_d   = r1_q;
      tag2_d = tag1_q;
      ov_d   = v2_q;
      if (v2_q) begin
        od_d = y_w;
        ot_d = tag2_q;
      end
    end
  end

  // Stage registers; reset drops every in-flight sample at once.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v1_q   <= 1'b0;
      k1_q   <= '0;
      r1_q   <= '0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      t2_q   <= '0;
      d2_q   <= '0;
      r2_q   <= '0;
      tag2_q <= '0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      ot_q   <= '0;
    end else begin
      v1_q   <= v1_d;
      k1_q   <= k1_d;
      r1_q   <= r1_d;
      tag1_q <= tag1_d;
      v2_q   <= v2_d;
      t2_q   <= t2_d;
      d2_q   <= d2_d;
      r2_q   <= r2_d;
      tag2_q <= tag2_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      ot_q   <= ot_d;
    end
  end

endmodule
